// File: rtl/gd_audio_pkg.sv
// Shared constants and helpers for the audio output stage.
// Mode encodings, gain scaling and signed saturation.
package gd_audio_pkg;

   localparam logic MODE_SIGMA_DELTA = 1'b0;
   localparam logic MODE_DITHER      = 1'b1;

   localparam logic [7:0] GAIN_UNITY = 8'd128;
   localparam int         GAIN_SHIFT = 7;

   // Clamp a signed value into the range of a w-bit signed number.
   function automatic logic signed [31:0] sat_signed(
      input logic signed [31:0] v,
      input int                 w
   );
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      hi = (32'sd1 <<< (w - 1)) - 32'sd1;
      lo = -(32'sd1 <<< (w - 1));
      if (v > hi)
         return hi;
      else if (v < lo)
         return lo;
      return v;
   endfunction

endpackage

// File: rtl/gd_sigma_delta_dac.sv
// One channel's 1-bit modulator: first-order sigma-delta
// or a signed compare against the sound counter as dither.
module gd_sigma_delta_dac
   import gd_audio_pkg::*;
#(
   parameter int DAC_W = 13
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic signed [DAC_W-1:0] level,
   input  logic        [DAC_W-1:0] dither,
   input  logic                    mode,
   output logic                    pin
);

   logic [DAC_W-1:0] u;
   logic [DAC_W-1:0] sd;
   logic [DAC_W:0]   sd_n;
   logic             cmp;

   // Offset-binary level feeds the accumulator; the carry is the pulse.
   assign u    = {~level[DAC_W-1], level[DAC_W-2:0]};
   assign sd_n = {1'b0, sd} + {1'b0, u};
   assign cmp  = level >= $signed(dither);

   // Accumulator runs in both modes so switching modes is seamless.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sd  <= '0;
         pin <= 1'b0;
      end else begin
         sd  <= sd_n[DAC_W-1:0];
         pin <= (mode == MODE_DITHER) ? cmp : sd_n[DAC_W];
      end
   end

endmodule

// File: rtl/gd_audio_out.sv
// Multi-channel audio output: box-filter decimation, gain,
// mute and saturation, then a 1-bit modulator per channel.
module gd_audio_out
   import gd_audio_pkg::*;
#(
   parameter int CHANNELS  = 2,
   parameter int SAMPLE_W  = 16,
   parameter int DAC_W     = 13,
   parameter int DIV_LOG2  = 6,
   parameter int COUNTER_W = 18
) (
   input  logic                         vga_clk,
   input  logic                         reset,
   input  logic [CHANNELS*SAMPLE_W-1:0] sample,
   input  logic [CHANNELS*8-1:0]        gain,
   input  logic                         mute,
   input  logic                         mode,
   output logic                         sample_strobe,
   output logic [COUNTER_W-1:0]         soundcounterOut,
   output logic [CHANNELS*DAC_W-1:0]    level,
   output logic [CHANNELS-1:0]          audio_out
);

   localparam int ACC_W  = SAMPLE_W + DIV_LOG2;
   localparam int PROD_W = DAC_W + 9;

   logic [COUNTER_W-1:0] cnt;
   logic [COUNTER_W-1:0] cnt_n;
   logic                 boundary;
   logic                 update;
   logic                 mute_q;

   assign cnt_n           = cnt + COUNTER_W'(1);
   assign boundary        = &cnt[DIV_LOG2-1:0];
   assign soundcounterOut = cnt;

   // Free-running counter, boundary strobe and the gain-stage trigger.
   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         cnt           <= '0;
         sample_strobe <= 1'b0;
         update        <= 1'b0;
         mute_q        <= 1'b0;
      end else begin
         cnt           <= cnt_n;
         sample_strobe <= &cnt_n[DIV_LOG2-1:0];
         update        <= boundary;
         if (boundary)
            mute_q <= mute;
      end
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic signed [SAMPLE_W-1:0] smp;
      logic signed [ACC_W-1:0]    acc;
      logic signed [ACC_W-1:0]    sum;
      logic signed [DAC_W-1:0]    avg;
      logic        [7:0]          gain_q;
      logic signed [PROD_W-1:0]   prod;
      logic signed [PROD_W-1:0]   scaled;
      logic signed [DAC_W-1:0]    lvl_q;

      assign smp    = sample[c*SAMPLE_W +: SAMPLE_W];
      assign sum    = acc + ACC_W'(smp);
      assign prod   = PROD_W'(avg) * PROD_W'($signed({1'b0, gain_q}));
      assign scaled = prod >>> GAIN_SHIFT;

      // Box filter: top DAC_W bits of the period sum are the floored mean.
      always_ff @(posedge vga_clk or posedge reset) begin
         if (reset) begin
            acc    <= '0;
            avg    <= '0;
            gain_q <= '0;
         end else if (boundary) begin
            acc    <= '0;
            avg    <= sum[ACC_W-1 -: DAC_W];
            gain_q <= gain[c*8 +: 8];
         end else begin
            acc    <= sum;
         end
      end

      // Gain, saturate and mute one cycle after the boundary.
      always_ff @(posedge vga_clk or posedge reset) begin
         if (reset)
            lvl_q <= '0;
         else if (update)
            lvl_q <= mute_q ? '0
                   : DAC_W'(sat_signed(32'(scaled), DAC_W));
      end

      assign level[c*DAC_W +: DAC_W] = lvl_q;

      gd_sigma_delta_dac #(
         .DAC_W (DAC_W)
      ) u_dac (
         .clk    (vga_clk),
         .reset  (reset),
         .level  (lvl_q),
         .dither (cnt[DAC_W-1:0]),
         .mode   (mode),
         .pin    (audio_out[c])
      );
   end

endmodule

// File: doc/gd_audio_out.md
Name: gd_audio_out

Overview:
- Parametrised multi-channel audio output stage.
- Box-filters signed PCM samples over a power-of-two decimation period, then applies per-channel gain, mute and saturation.
- Drives each channel's 1-bit pin through a selectable first-order sigma-delta or dithered-compare modulator.
- Sits between the audio sample mixer and the board audio pins; it also publishes the free-running sound counter to the voice/sample engines.

Parameters:
- CHANNELS, 2: number of output channels.
- SAMPLE_W, 16: signed input sample width.
- DAC_W, 13: signed modulator input width. Requires 2 <= DAC_W <= SAMPLE_W.
- DIV_LOG2, 6: log2 of the decimation period in clocks. Requires DIV_LOG2 >= 1.
- COUNTER_W, 18: width of the free-running sound counter. Requires COUNTER_W >= max(DIV_LOG2, DAC_W).

Ports:
- vga_clk  input  1: the single clock; all logic rises on it.
- reset  input  1: asynchronous, active-high reset.
- sample  input  CHANNELS*SAMPLE_W: packed signed samples; channel c is bits [c*SAMPLE_W +: SAMPLE_W]. Sampled every cycle.
- gain  input  CHANNELS*8: packed unsigned per-channel gain; 128 = unity.
- mute  input  1: forces all levels to 0 at the next period boundary.
- mode  input  1: 0 = sigma-delta, 1 = dithered compare.
- sample_strobe  output  1: one-cycle pulse on the last cycle of each period.
- soundcounterOut  output  COUNTER_W: the free-running counter.
- level  output  CHANNELS*DAC_W: packed signed level currently being modulated.
- audio_out  output  CHANNELS: registered 1-bit pin drive, one bit per channel.

Behaviour:
- Reset (async assert, sync release): counter 0, all accumulators 0, average 0, level 0, sigma-delta accumulators 0. Outputs: audio_out 0, sample_strobe 0, soundcounterOut 0, level 0.
- Counter: increments by 1 every cycle and wraps at 2^COUNTER_W. Phase = counter[DIV_LOG2-1:0]. The boundary is phase == all-ones.
- sample_strobe = registered (next phase == all-ones). It is high exactly during boundary cycles, once every 2^DIV_LOG2 cycles. It is first high on cycle 2^DIV_LOG2 - 1 after reset release.
- Accumulator per channel: signed, SAMPLE_W+DIV_LOG2 bits, sign-extended add.
  - Non-boundary cycle: acc <= acc + sample.
  - Boundary cycle: avg <= bits [SAMPLE_W+DIV_LOG2-1 -: DAC_W] of (acc + sample), i.e. the mean of 2^DIV_LOG2 samples truncated (floor) to DAC_W; then acc <= 0.
  - The sum cannot overflow, so no saturation is needed here.
- Gain stage, registered one cycle after the boundary:
  - p = avg * {0,gain}, signed, DAC_W+9 bits.
  - s = p >>> 7, arithmetic (floor).
  - level <= s saturated to [-2^(DAC_W-1), 2^(DAC_W-1)-1].
  - If mute was high on the boundary cycle, level <= 0 instead.
  - gain and mute are sampled on the boundary cycle only.
- Latency: the first sample of a period reaches level 2^DIV_LOG2 + 1 cycles after it is presented. level holds its value between updates.
- Sigma-delta (per channel):
  - u = level with its MSB inverted (offset binary).
  - sd is DAC_W+1 bits: sd <= {0, sd[DAC_W-1:0]} + u. It runs every cycle in both modes.
  - In mode 0: audio_out[c] <= sd carry (next-state bit DAC_W).
  - Pulse density is u/2^DAC_W. u = 0 gives constant 0; u = 2^DAC_W - 1 gives exactly one 0 per 2^DAC_W cycles.
- Dithered compare, mode 1: audio_out[c] <= (level >= signed counter[DAC_W-1:0]), a signed comparison.
- Mode change takes effect on the next cycle. It causes no reset of sd, the counter or the accumulators.
- Reset mid-period: the partial accumulation is discarded and audio_out drops to 0 immediately. The period restarts at phase 0.
- Gain 0 gives level 0. Gain 255 saturates for |avg| > 2^(DAC_W-1)*128/255.

Decomposition:
- Package gd_audio_pkg holds:
  - MODE_SIGMA_DELTA = 1'b0 and MODE_DITHER = 1'b1;
  - GAIN_UNITY = 8'd128, GAIN_SHIFT = 7;
  - a saturate-to-width function.
- Sub-module gd_sigma_delta_dac holds one channel's modulator (level, counter slice, mode → audio bit). Parameter: DAC_W. It is instantiated CHANNELS times in a generate loop.

Test Plan:
1. Reset then constant sample 0, gain 128, mode 0 → level stays 0 (u = 4096); each channel toggles 1/0 alternately after settling; sample_strobe first high on cycle 63, period 64.
2. Constant +32767, gain 128 → level = 4095 at cycle 65; audio_out low exactly once per 8192 cycles. Constant −32768 → level −4096, audio_out constant 0.
3. Ramp: sample = 64*phase for one period (sum 129024) → avg = 129024>>9 = 252, level 252 one cycle after boundary; next period all 0 → level 0.
4. Gain/mute: avg 2000 with gain 255 → 3984; avg 4000 with gain 255 → saturate 4095; avg −2000 with gain 64 → −1000; mute high at boundary → 0; CH0 and CH1 with different gains stay independent.
5. Mode 1 with level 0 → audio_out = 1 whenever counter[12] = 1 or counter[12:0] = 0, i.e. density 4097/8192. Switch mode mid-period → pin follows the new mode the next cycle; level unchanged.
6. Assert reset at phase 30 with audio_out = 1 → all outputs 0 asynchronously; after release, level still 0 and sample_strobe next high on cycle 63.
